// File: rtl/connect4_pkg.sv
// Shared encodings for the connect-four engine: cell and winner codes,
// controller states and the per-direction scan step table.
package connect4_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLACE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Scan order: horizontal, vertical, diagonal (+1,+1), anti-diagonal (+1,-1).
  localparam logic signed [1:0] STEP_DX [4] = '{2'sd1, 2'sd0, 2'sd1, 2'sd1};
  localparam logic signed [1:0] STEP_DY [4] = '{2'sd0, 2'sd1, 2'sd1, -2'sd1};

endpackage

// File: rtl/connect4_edge_sync.sv
// Two-flop synchroniser for a raw pushbutton level followed by a
// falling-edge detector; o_fall is a one-cycle pulse per 1->0 change.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Sync chain idles high so a button held through reset is not a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/connect4_engine.sv
// Connect-four move engine: accepts debounced drop requests, places the
// piece in a flop-based board, then walks the four line directions one
// cell per cycle to detect a win or a full-board draw.
module connect4_engine
  import connect4_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int MW = $clog2(COLS*ROWS+1)
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic [CW-1:0] col_sel,
  input  logic          drop_n,
  input  logic [CW-1:0] rd_col,
  input  logic [RW-1:0] rd_row,
  output logic [1:0]    rd_cell,
  output logic          player,
  output logic          busy,
  output logic          reject,
  output logic [1:0]    winner,
  output logic          game_over,
  output logic [MW-1:0] moves,
  output logic [1:0]    dbg_state
);

  localparam int HW = $clog2(ROWS+1);
  localparam int NW = $clog2(WIN_LEN+1);
  localparam logic [CW:0]    COLS_W  = (CW+1)'(COLS);
  localparam logic [RW:0]    ROWS_W  = (RW+1)'(ROWS);
  localparam logic [HW-1:0]  ROWS_H  = HW'(ROWS);
  localparam logic [NW-1:0]  WIN_N   = NW'(WIN_LEN);
  localparam logic [MW-1:0]  TOTAL_M = MW'(COLS*ROWS);

  state_t              r_state;
  logic [1:0]          r_board  [COLS][ROWS];
  logic [HW-1:0]       r_height [COLS];
  logic                r_player;
  logic                r_busy;
  logic                r_reject;
  logic                r_mover;
  logic                r_side;     // 0: stepping +dir, 1: stepping -dir
  logic [1:0]          r_winner;
  logic [1:0]          r_dir;
  logic [MW-1:0]       r_moves;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [NW-1:0]       r_cnt;
  logic signed [CW+1:0] r_px;
  logic signed [RW+1:0] r_py;

  logic                w_req;
  logic                w_col_ok;
  logic [HW-1:0]       w_col_h;
  logic                w_bad;
  logic [1:0]          w_code;
  logic signed [1:0]   w_sdx;
  logic signed [1:0]   w_sdy;
  logic signed [CW+1:0] w_dx;
  logic signed [RW+1:0] w_dy;
  logic signed [CW+1:0] w_nx;
  logic signed [RW+1:0] w_ny;
  logic signed [CW+1:0] w_px0;
  logic signed [RW+1:0] w_py0;
  logic                w_in;
  logic [1:0]          w_cell;
  logic                w_match;
  logic [NW-1:0]       w_cnt_nx;

  edge_sync u_drop_sync (
    .i_clk   (CLOCK_50),
    .i_rst_n (resetn),
    .i_d     (drop_n),
    .o_fall  (w_req)
  );

  // An out-of-range column is treated as a full one so one test covers both.
  assign w_col_ok = ({1'b0, col_sel} < COLS_W);
  assign w_col_h  = w_col_ok ? r_height[col_sel] : ROWS_H;
  assign w_bad    = (w_col_h == ROWS_H);
  assign w_code   = r_mover ? P2 : P1;

  assign w_sdx = STEP_DX[r_dir];
  assign w_sdy = STEP_DY[r_dir];
  assign w_dx  = {{CW{w_sdx[1]}}, w_sdx};
  assign w_dy  = {{RW{w_sdy[1]}}, w_sdy};
  assign w_nx  = r_side ? (r_px - w_dx) : (r_px + w_dx);
  assign w_ny  = r_side ? (r_py - w_dy) : (r_py + w_dy);
  assign w_px0 = {2'b00, r_col};
  assign w_py0 = {2'b00, r_row};

  assign w_in = ~w_nx[CW+1] & (w_nx[CW:0] < COLS_W) &
                ~w_ny[RW+1] & (w_ny[RW:0] < ROWS_W);
  assign w_cell   = r_board[w_nx[CW-1:0]][w_ny[RW-1:0]];
  assign w_match  = w_in & (w_cell == w_code);
  assign w_cnt_nx = r_cnt + NW'(1);

  // Move controller, board and column heights share one reset domain so a
  // reset mid-move leaves nothing of the abandoned move behind.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_player <= 1'b0;
      r_busy   <= 1'b0;
      r_reject <= 1'b0;
      r_mover  <= 1'b0;
      r_side   <= 1'b0;
      r_winner <= WIN_NONE;
      r_dir    <= 2'd0;
      r_moves  <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_cnt    <= '0;
      r_px     <= '0;
      r_py     <= '0;
      for (int c = 0; c < COLS; c++) begin
        r_height[c] <= '0;
        for (int r = 0; r < ROWS; r++) r_board[c][r] <= EMPTY;
      end
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_bad) begin
              r_reject <= 1'b1;
            end else begin
              r_state <= ST_PLACE;
              r_busy  <= 1'b1;
              r_col   <= col_sel;
              r_row   <= w_col_h[RW-1:0];
              r_mover <= r_player;
            end
          end
        end
        ST_PLACE: begin
          r_board[r_col][r_row] <= w_code;
          r_height[r_col]       <= r_height[r_col] + HW'(1);
          r_moves               <= r_moves + MW'(1);
          r_dir   <= 2'd0;
          r_side  <= 1'b0;
          r_cnt   <= NW'(1);
          r_px    <= w_px0;
          r_py    <= w_py0;
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_match) begin
            r_cnt <= w_cnt_nx;
            r_px  <= w_nx;
            r_py  <= w_ny;
            if (w_cnt_nx >= WIN_N) begin
              r_winner <= r_mover ? WIN_P2 : WIN_P1;
              r_busy   <= 1'b0;
              r_state  <= ST_DONE;
            end
          end else if (!r_side) begin
            r_side <= 1'b1;
            r_px   <= w_px0;
            r_py   <= w_py0;
          end else if (r_dir != 2'd3) begin
            r_dir  <= r_dir + 2'd1;
            r_side <= 1'b0;
            r_cnt  <= NW'(1);
            r_px   <= w_px0;
            r_py   <= w_py0;
          end else begin
            r_busy <= 1'b0;
            if (r_moves == TOTAL_M) begin
              r_winner <= WIN_DRAW;
              r_state  <= ST_DONE;
            end else begin
              r_player <= ~r_player;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  // Combinational board read; addresses off the board read as empty.
  always_comb begin
    rd_cell = EMPTY;
    if (({1'b0, rd_col} < COLS_W) && ({1'b0, rd_row} < ROWS_W))
      rd_cell = r_board[rd_col][rd_row];
  end

  assign player    = r_player;
  assign busy      = r_busy;
  assign reject    = r_reject;
  assign winner    = r_winner;
  assign game_over = (r_winner != WIN_NONE);
  assign moves     = r_moves;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_connect4_engine.sv
// Bench for connect4_engine: a default 7x6 board (instance a) and a 4x4
// board (instance b) driven with scripted games.
module tb_connect4_engine;

  logic clk;
  logic rst_n_a, rst_n_b;

  logic [2:0] col_sel_a, rd_col_a, rd_row_a;
  logic       drop_n_a;
  logic [1:0] rd_cell_a, winner_a, dbg_a;
  logic       player_a, busy_a, reject_a, game_over_a;
  logic [5:0] moves_a;

  logic [1:0] col_sel_b, rd_col_b, rd_row_b;
  logic       drop_n_b;
  logic [1:0] rd_cell_b, winner_b, dbg_b;
  logic       player_b, busy_b, reject_b, game_over_b;
  logic [4:0] moves_b;

  // Event record: {reject, winner[1:0], game_over, moves[5:0], player}
  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];

  int n_checks = 0;
  int n_errors = 0;

  connect4_engine u_dut_a (
    .CLOCK_50(clk), .resetn(rst_n_a), .col_sel(col_sel_a), .drop_n(drop_n_a),
    .rd_col(rd_col_a), .rd_row(rd_row_a), .rd_cell(rd_cell_a),
    .player(player_a), .busy(busy_a), .reject(reject_a), .winner(winner_a),
    .game_over(game_over_a), .moves(moves_a), .dbg_state(dbg_a)
  );

  connect4_engine #(.COLS(4), .ROWS(4), .WIN_LEN(4)) u_dut_b (
    .CLOCK_50(clk), .resetn(rst_n_b), .col_sel(col_sel_b), .drop_n(drop_n_b),
    .rd_col(rd_col_b), .rd_row(rd_row_b), .rd_cell(rd_cell_b),
    .player(player_b), .busy(busy_b), .reject(reject_b), .winner(winner_b),
    .game_over(game_over_b), .moves(moves_b), .dbg_state(dbg_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int which, input bit rej, input logic [1:0] win,
                      input bit go, input int mv, input bit pl);
    logic [10:0] e;
    e = {rej, win, go, 6'(mv), pl};
    if (which == 0) exp_q_a.push_back(e);
    else            exp_q_b.push_back(e);
  endtask

  task automatic drop(input int which, input int col, input int hold);
    logic b;
    if (which == 0) begin col_sel_a = 3'(col); drop_n_a = 1'b0; end
    else            begin col_sel_b = 2'(col); drop_n_b = 1'b0; end
    repeat (hold) tick();
    if (which == 0) drop_n_a = 1'b1;
    else            drop_n_b = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 200; i++) begin
      b = (which == 0) ? busy_a : busy_b;
      if (!b) break;
      tick();
    end
    b = (which == 0) ? busy_a : busy_b;
    if (b) chk("busy_timeout", 32'(b), 32'd0);
    repeat (2) tick();
  endtask

  task automatic reset_dut(input int which);
    if (which == 0) rst_n_a = 1'b0; else rst_n_b = 1'b0;
    repeat (3) tick();
    if (which == 0) rst_n_a = 1'b1; else rst_n_b = 1'b1;
    repeat (4) tick();
  endtask

  // Monitor a: one record per completed move (busy fall) or reject pulse
  logic prev_busy_a = 1'b0;
  int   bcnt_a = 0;
  always @(negedge clk) begin
    logic [10:0] act, exp;
    if (!rst_n_a) begin
      prev_busy_a = 1'b0;
      bcnt_a = 0;
    end else begin
      if (busy_a) bcnt_a++;
      if ((prev_busy_a && !busy_a) || reject_a) begin
        act = {reject_a, winner_a, game_over_a, moves_a, player_a};
        if (exp_q_a.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL event_a: got %0h expected none", act);
        end else begin
          exp = exp_q_a.pop_front();
          chk("event_a", 32'(act), 32'(exp));
        end
        if (!reject_a) begin
          n_checks++;
          if (bcnt_a > 29) begin
            n_errors++;
            $display("FAIL latency_a: got %0d cycles required at most 29", bcnt_a);
          end
        end
        bcnt_a = 0;
      end
      prev_busy_a = busy_a;
    end
  end

  // Monitor b
  logic prev_busy_b = 1'b0;
  int   bcnt_b = 0;
  always @(negedge clk) begin
    logic [10:0] act, exp;
    if (!rst_n_b) begin
      prev_busy_b = 1'b0;
      bcnt_b = 0;
    end else begin
      if (busy_b) bcnt_b++;
      if ((prev_busy_b && !busy_b) || reject_b) begin
        act = {reject_b, winner_b, game_over_b, 1'b0, moves_b, player_b};
        if (exp_q_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL event_b: got %0h expected none", act);
        end else begin
          exp = exp_q_b.pop_front();
          chk("event_b", 32'(act), 32'(exp));
        end
        if (!reject_b) begin
          n_checks++;
          if (bcnt_b > 29) begin
            n_errors++;
            $display("FAIL latency_b: got %0d cycles required at most 29", bcnt_b);
          end
        end
        bcnt_b = 0;
      end
      prev_busy_b = busy_b;
    end
  end

  int seq_v[7] = '{3, 4, 3, 4, 3, 4, 3};
  int seq_h[7] = '{0, 6, 1, 6, 2, 6, 3};
  int seq_d[16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    drop_n_a = 1'b1; drop_n_b = 1'b1;
    col_sel_a = '0; col_sel_b = '0;
    rd_col_a = '0; rd_row_a = '0; rd_col_b = '0; rd_row_b = '0;
    repeat (3) tick();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (4) tick();

    // Reset values
    chk("rst_player_a", 32'(player_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_reject_a", 32'(reject_a), 0);
    chk("rst_winner_a", 32'(winner_a), 0);
    chk("rst_game_over_a", 32'(game_over_a), 0);
    chk("rst_moves_a", 32'(moves_a), 0);
    chk("rst_cell_a", 32'(rd_cell_a), 0);
    chk("rst_moves_b", 32'(moves_b), 0);
    chk("rst_winner_b", 32'(winner_b), 0);

    // Vertical win in column 3
    for (int k = 0; k < 7; k++)
      push(0, 0, (k == 6) ? 2'b01 : 2'b00, k == 6, k + 1, (k == 6) ? 1'b0 : 1'((k + 1) % 2));
    for (int k = 0; k < 7; k++) drop(0, seq_v[k], 4);
    chk("vert_winner", 32'(winner_a), 32'h1);
    chk("vert_game_over", 32'(game_over_a), 1);
    chk("vert_moves", 32'(moves_a), 7);
    rd_col_a = 3; rd_row_a = 3; #1 chk("vert_cell_3_3", 32'(rd_cell_a), 32'h1);
    rd_col_a = 4; rd_row_a = 2; #1 chk("vert_cell_4_2", 32'(rd_cell_a), 32'h2);
    rd_col_a = 4; rd_row_a = 3; #1 chk("vert_cell_4_3", 32'(rd_cell_a), 32'h0);
    rd_col_a = 7; rd_row_a = 0; #1 chk("cell_out_of_range", 32'(rd_cell_a), 32'h0);
    drop(0, 0, 4);
    chk("done_ignores_moves", 32'(moves_a), 7);
    chk("done_player_frozen", 32'(player_a), 0);

    // Horizontal win along the bottom row
    reset_dut(0);
    for (int k = 0; k < 7; k++)
      push(0, 0, (k == 6) ? 2'b01 : 2'b00, k == 6, k + 1, (k == 6) ? 1'b0 : 1'((k + 1) % 2));
    for (int k = 0; k < 7; k++) drop(0, seq_h[k], 4);
    chk("horiz_winner", 32'(winner_a), 32'h1);
    rd_col_a = 3; rd_row_a = 0; #1 chk("horiz_cell_3_0", 32'(rd_cell_a), 32'h1);
    rd_col_a = 6; rd_row_a = 2; #1 chk("horiz_cell_6_2", 32'(rd_cell_a), 32'h2);

    // Full column, illegal column, and a held button
    reset_dut(0);
    for (int k = 0; k < 6; k++) push(0, 0, 2'b00, 0, k + 1, 1'((k + 1) % 2));
    push(0, 1, 2'b00, 0, 6, 0);
    push(0, 1, 2'b00, 0, 6, 0);
    push(0, 0, 2'b00, 0, 7, 1);
    for (int k = 0; k < 6; k++) drop(0, 2, 4);
    drop(0, 2, 4);
    chk("full_col_moves", 32'(moves_a), 6);
    chk("full_col_player", 32'(player_a), 0);
    drop(0, 7, 4);
    drop(0, 0, 1000);
    chk("held_moves", 32'(moves_a), 7);
    chk("held_player", 32'(player_a), 1);

    // Reset in the middle of the win scan
    reset_dut(0);
    push(0, 0, 2'b00, 0, 1, 1);
    drop(0, 5, 4);
    col_sel_a = 5;
    drop_n_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_a == 2'd2) break;
      tick();
    end
    chk("reach_check", 32'(dbg_a), 2);
    #1 rst_n_a = 1'b0;
    #1;
    chk("async_busy", 32'(busy_a), 0);
    chk("async_moves", 32'(moves_a), 0);
    chk("async_player", 32'(player_a), 0);
    chk("async_winner", 32'(winner_a), 0);
    chk("async_state", 32'(dbg_a), 0);
    rd_col_a = 5; rd_row_a = 0; #1 chk("async_cell_5_0", 32'(rd_cell_a), 32'h0);
    drop_n_a = 1'b1;
    repeat (3) tick();
    rst_n_a = 1'b1;
    repeat (4) tick();
    push(0, 0, 2'b00, 0, 1, 1);
    drop(0, 5, 4);
    rd_col_a = 5; rd_row_a = 0; #1 chk("after_rst_cell_5_0", 32'(rd_cell_a), 32'h1);
    rd_col_a = 5; rd_row_a = 1; #1 chk("after_rst_cell_5_1", 32'(rd_cell_a), 32'h0);

    // 4x4 board filled without any line of four
    for (int k = 0; k < 16; k++)
      push(1, 0, (k == 15) ? 2'b11 : 2'b00, k == 15, k + 1, (k == 15) ? 1'b1 : 1'((k + 1) % 2));
    for (int k = 0; k < 16; k++) drop(1, seq_d[k], 4);
    chk("draw_winner", 32'(winner_b), 32'h3);
    chk("draw_game_over", 32'(game_over_b), 1);
    chk("draw_moves", 32'(moves_b), 16);
    rd_col_b = 2; rd_row_b = 3; #1 chk("draw_cell_2_3", 32'(rd_cell_b), 32'h1);
    rd_col_b = 1; rd_row_b = 3; #1 chk("draw_cell_1_3", 32'(rd_cell_b), 32'h2);
    drop(1, 0, 4);
    chk("draw_ignores_moves", 32'(moves_b), 16);
    chk("draw_ignores_winner", 32'(winner_b), 32'h3);

    repeat (5) tick();
    chk("queue_a_drained", 32'(exp_q_a.size()), 0);
    chk("queue_b_drained", 32'(exp_q_b.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
